// File: rtl/alu_dispatch.sv
// alu_dispatch: serialized issue stage for the 64-bit ALU (IDLE -> READ -> EXEC).
// Optional retire counter port enabled by defining ALU_DISPATCH_RETIRE_CNT_EN.
module alu_dispatch #(
  parameter int NREGS  = 8,
  parameter int RIDX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready depends only on state, never on in_valid.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_cmd,
  input  logic [6:0]        in_opm,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [RIDX_W-1:0] in_ra,
  input  logic [RIDX_W-1:0] in_rb,
  input  logic [1:0]        in_imm_sel,
  input  logic [63:0]       in_imm,
  output logic [4:0]        alu_cmd,
  output logic [6:0]        alu_opm,
  output logic [63:0]       alu_a,
  output logic [63:0]       alu_b,
  input  logic [63:0]       alu_out,
  output logic              wb_valid,
  output logic [RIDX_W-1:0] wb_rd,
  output logic [63:0]       wb_data,
  output logic [1:0]        dbg_state_o
`ifdef ALU_DISPATCH_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Instruction buffer, written only on the accept edge.
  logic [4:0]        cmd_q, cmd_d;
  logic [6:0]        opm_q, opm_d;
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic [RIDX_W-1:0] ra_q, ra_d;
  logic [RIDX_W-1:0] rb_q, rb_d;
  logic [1:0]        imm_sel_q, imm_sel_d;
  logic [63:0]       imm_q, imm_d;

  logic [63:0]       regs_q [NREGS];
  logic [63:0]       regs_d [NREGS];

  logic [4:0]        alu_cmd_q, alu_cmd_d;
  logic [6:0]        alu_opm_q, alu_opm_d;
  logic [63:0]       alu_a_q, alu_a_d;
  logic [63:0]       alu_b_q, alu_b_d;

  logic              wb_valid_q, wb_valid_d;
  logic [RIDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [63:0]       wb_data_q, wb_data_d;

  logic              accept;
  logic [63:0]       rf_a, rf_b;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready;

  // r0 is hardwired to zero regardless of what its storage holds.
  assign rf_a = (ra_q == '0) ? 64'd0 : regs_q[ra_q];
  assign rf_b = (rb_q == '0) ? 64'd0 : regs_q[rb_q];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    opm_d      = opm_q;
    rd_d       = rd_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    imm_sel_d  = imm_sel_q;
    imm_d      = imm_q;
    regs_d     = regs_q;
    alu_cmd_d  = alu_cmd_q;
    alu_opm_d  = alu_opm_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d     = in_cmd;
          opm_d     = in_opm;
          rd_d      = in_rd;
          ra_d      = in_ra;
          rb_d      = in_rb;
          imm_sel_d = in_imm_sel;
          imm_d     = in_imm;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        alu_cmd_d = cmd_q;
        alu_opm_d = opm_q;
        alu_a_d   = imm_sel_q[0] ? imm_q : rf_a;
        alu_b_d   = imm_sel_q[1] ? imm_q : rf_b;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        if (rd_q != '0) begin
          regs_d[rd_q] = alu_out;
        end
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = alu_out;
        // Return the ALU to ZERO so stateful commands fire exactly once.
        alu_cmd_d  = 5'd0;
        alu_a_d    = 64'd0;
        alu_b_d    = 64'd0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      opm_q      <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      imm_sel_q  <= '0;
      imm_q      <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      alu_cmd_q  <= '0;
      alu_opm_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      opm_q      <= opm_d;
      rd_q       <= rd_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      imm_sel_q  <= imm_sel_d;
      imm_q      <= imm_d;
      regs_q     <= regs_d;
      alu_cmd_q  <= alu_cmd_d;
      alu_opm_q  <= alu_opm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef ALU_DISPATCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Counts every EXEC->IDLE transition, rd=0 included; wraps naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (state_q == S_EXEC) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign alu_cmd     = alu_cmd_q;
  assign alu_opm     = alu_opm_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Testbench for alu_dispatch: stand-in ALU, per-cycle monitor against a
// transaction-level model (register array + expected writeback queue).
module tb_alu_dispatch;

  localparam int NREGS  = 8;
  localparam int RIDX_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_cmd = '0;
  logic [6:0]        in_opm = '0;
  logic [RIDX_W-1:0] in_rd = '0, in_ra = '0, in_rb = '0;
  logic [1:0]        in_imm_sel = '0;
  logic [63:0]       in_imm = '0;
  logic [4:0]        alu_cmd;
  logic [6:0]        alu_opm;
  logic [63:0]       alu_a, alu_b, alu_out;
  logic              wb_valid;
  logic [RIDX_W-1:0] wb_rd;
  logic [63:0]       wb_data;
  logic [1:0]        dbg_state;
`ifdef ALU_DISPATCH_RETIRE_CNT_EN
  logic [31:0]       retire_cnt;
`endif

  alu_dispatch #(.NREGS(NREGS), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_opm(in_opm), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .alu_cmd(alu_cmd), .alu_opm(alu_opm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_state_o(dbg_state)
`ifdef ALU_DISPATCH_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  // Stand-in combinational ALU: 0 ZERO, 1 SIGN(b), 2 ADD, 3 SUB, 4 INV(a), 5 XOR, 6 AND, 7 OR.
  function automatic logic [63:0] alu_fn(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b);
    case (c)
      5'd0: return 64'd0;
      5'd1: return (b == 64'd0) ? 64'd0 : (b[63] ? '1 : 64'd1);
      5'd2: return a + b;
      5'd3: return a - b;
      5'd4: return ~a;
      5'd5: return a ^ b;
      5'd6: return a & b;
      5'd7: return a | b;
      default: return {a[31:0], b[31:0]};
    endcase
  endfunction

  assign alu_out = alu_fn(alu_cmd, alu_a, alu_b);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [63:0]       m_rf [NREGS];
  logic [63:0]       exp_q [$];
  logic [RIDX_W-1:0] exp_rd_q [$];
  int                ready_cyc = 0, exec_cyc = -1, wb_cyc = -1;
  logic [4:0]        cur_cmd = '0;
  logic [6:0]        cur_opm = '0, last_opm = '0;
  logic [63:0]       cur_a = '0, cur_b = '0, last_wb_data = '0;
  logic [RIDX_W-1:0] last_wb_rd = '0;
  logic [31:0]       m_retire = '0;
  bit                checking = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    exp_q.delete();
    exp_rd_q.delete();
    ready_cyc = 0; exec_cyc = -1; wb_cyc = -1;
    last_opm = '0; last_wb_data = '0; last_wb_rd = '0; m_retire = '0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      if (cyc == exec_cyc) last_opm = cur_opm;
      if (cyc == wb_cyc) begin
        m_retire = m_retire + 32'd1;
        if (exp_q.size() > 0) begin
          last_wb_data = exp_q.pop_front();
          last_wb_rd   = exp_rd_q.pop_front();
        end
      end
      check_eq("in_ready", 64'(in_ready), 64'(cyc >= ready_cyc));
      check_eq("alu_cmd",  64'(alu_cmd), (cyc == exec_cyc) ? 64'(cur_cmd) : 64'd0);
      check_eq("alu_a",    alu_a, (cyc == exec_cyc) ? cur_a : 64'd0);
      check_eq("alu_b",    alu_b, (cyc == exec_cyc) ? cur_b : 64'd0);
      check_eq("alu_opm",  64'(alu_opm), 64'(last_opm));
      check_eq("wb_valid", 64'(wb_valid), 64'(cyc == wb_cyc));
      check_eq("wb_rd",    64'(wb_rd), 64'(last_wb_rd));
      check_eq("wb_data",  wb_data, last_wb_data);
`ifdef ALU_DISPATCH_RETIRE_CNT_EN
      check_eq("retire_cnt", 64'(retire_cnt), 64'(m_retire));
`endif
      if (!rst_n) begin
        model_reset();
      end else if (in_valid && cyc >= ready_cyc) begin
        cur_cmd = in_cmd;
        cur_opm = in_opm;
        cur_a   = in_imm_sel[0] ? in_imm : m_rf[in_ra];
        cur_b   = in_imm_sel[1] ? in_imm : m_rf[in_rb];
        exp_q.push_back(alu_fn(in_cmd, cur_a, cur_b));
        exp_rd_q.push_back(in_rd);
        if (in_rd != '0) m_rf[in_rd] = alu_fn(in_cmd, cur_a, cur_b);
        exec_cyc  = cyc + 2;
        wb_cyc    = cyc + 3;
        ready_cyc = cyc + 3;
      end
    end else if (!rst_n) begin
      model_reset();
      checking = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] cmd, input logic [RIDX_W-1:0] rd, input logic [RIDX_W-1:0] ra,
                       input logic [RIDX_W-1:0] rb, input logic [1:0] sel, input logic [63:0] imm,
                       input bit junk);
    bit done = 1'b0;
    in_cmd = cmd; in_opm = 7'($urandom_range(0, 127)); in_rd = rd; in_ra = ra; in_rb = rb;
    in_imm_sel = sel; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) check_eq("accept_timeout", 64'd0, 64'd1);
    // Garbage offered while busy must be ignored.
    if (junk && done) begin
      for (int j = 0; j < 2; j++) begin
        in_cmd = 5'($urandom_range(0, 31)); in_opm = 7'($urandom_range(0, 127));
        in_rd = RIDX_W'($urandom_range(0, NREGS - 1)); in_ra = RIDX_W'($urandom_range(0, NREGS - 1));
        in_rb = RIDX_W'($urandom_range(0, NREGS - 1)); in_imm_sel = 2'($urandom_range(0, 3));
        in_imm = {$urandom, $urandom};
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Wait from the cycle after accept to the writeback cycle and check literal values.
  task automatic expect_wb(input string tag, input logic [RIDX_W-1:0] rd, input logic [63:0] data);
    idle(2);
    check_eq({tag, "_valid"}, 64'(wb_valid), 64'd1);
    check_eq({tag, "_rd"}, 64'(wb_rd), 64'(rd));
    check_eq({tag, "_data"}, wb_data, data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    check_eq("post_reset_ready", 64'(in_ready), 64'd1);

    // All registers read 0 after reset.
    issue(5'd7, 3'd5, 3'd3, 3'd6, 2'b00, 64'd0, 1'b0);
    expect_wb("rf_zero", 3'd5, 64'd0);

    issue(5'd4, 3'd1, 3'd0, 3'd0, 2'b01, 64'd0, 1'b0);
    expect_wb("inv", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(5'd1, 3'd2, 3'd0, 3'd1, 2'b00, 64'd0, 1'b0);
    expect_wb("sign", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(5'd2, 3'd4, 3'd2, 3'd0, 2'b00, 64'd0, 1'b0);
    expect_wb("read_r2", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back with in_valid held high and junk during busy cycles.
    issue(5'd2, 3'd3, 3'd1, 3'd0, 2'b10, 64'd5, 1'b1);
    issue(5'd3, 3'd5, 3'd3, 3'd3, 2'b00, 64'd0, 1'b1);
    issue(5'd5, 3'd6, 3'd0, 3'd0, 2'b11, 64'h0123_4567_89AB_CDEF, 1'b1);
    idle(2);

    // rd = 0: reported but never stored.
    issue(5'd4, 3'd0, 3'd0, 3'd0, 2'b01, 64'd0, 1'b0);
    expect_wb("rd0", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(5'd7, 3'd7, 3'd0, 3'd0, 2'b00, 64'd0, 1'b0);
    expect_wb("r0_read", 3'd7, 64'd0);

    // Reset during EXEC of a write to r3.
    issue(5'd2, 3'd3, 3'd0, 3'd0, 2'b11, 64'd9, 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_eq("rst_exec_no_wb", 64'(wb_valid), 64'd0);
    issue(5'd2, 3'd4, 3'd3, 3'd0, 2'b00, 64'd0, 1'b0);
    expect_wb("r3_cleared", 3'd4, 64'd0);
    issue(5'd4, 3'd1, 3'd0, 3'd0, 2'b01, 64'd3, 1'b1);
    issue(5'd2, 3'd2, 3'd1, 3'd1, 2'b00, 64'd0, 1'b0);
    idle(3);
`ifdef ALU_DISPATCH_RETIRE_CNT_EN
    check_eq("retire_three", 64'(retire_cnt), 64'd3);
`endif

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      idle($urandom_range(0, 3));
      issue(5'($urandom_range(0, 9)), RIDX_W'($urandom_range(0, NREGS - 1)),
            RIDX_W'($urandom_range(0, NREGS - 1)), RIDX_W'($urandom_range(0, NREGS - 1)),
            2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    idle(6);
    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog @cyc %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue stage directly upstream of the 64-bit ALU (7-bit opm, 5-bit cmd, signed 64-bit a/b/out).
- Accepts instructions over a valid/ready handshake and reads operands from a local register file or an immediate.
- Drives the combinational ALU for exactly one cycle, captures the ALU result, writes it back and reports it on a writeback bus.
- Strictly serialized: one instruction in flight, so there are no hazards.

Parameters:
- NREGS, 8, number of 64-bit registers; r0 is hardwired to zero.
- RIDX_W, 3, register index width; must equal log2(NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  dispatcher can accept.
- in_cmd  in  5  ALU command.
- in_opm  in  7  ALU operating mode, passed through.
- in_rd  in  RIDX_W  destination register.
- in_ra  in  RIDX_W  source register for operand a.
- in_rb  in  RIDX_W  source register for operand b.
- in_imm_sel  in  2  bit0: a = in_imm; bit1: b = in_imm.
- in_imm  in  64  immediate value.
- alu_cmd  out  5  to ALU cmd.
- alu_opm  out  7  to ALU opm.
- alu_a  out  64  to ALU a.
- alu_b  out  64  to ALU b.
- alu_out  in  64  from ALU out (combinational).
- wb_valid  out  1  one-cycle result pulse.
- wb_rd  out  RIDX_W  destination of the reported result.
- wb_data  out  64  reported result.

Behaviour:
- FSM states: IDLE, READ, EXEC.
  - in_ready = 1 only in IDLE.
  - Accept = in_valid & in_ready.
- IDLE:
  - On accept, latch cmd/opm/rd/ra/rb/imm_sel/imm into the instruction buffer; go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Read regfile[ra] and regfile[rb] (r0 reads 0).
  - Apply imm_sel; imm_sel=2'b11 puts in_imm on both a and b.
  - Register the results into alu_a/alu_b; register alu_cmd/alu_opm from the buffer; go to EXEC.
- EXEC:
  - ALU inputs are stable for the whole cycle.
  - At the end of EXEC: regfile[rd] <= alu_out (discarded if rd=0); wb_valid <= 1, wb_rd <= rd, wb_data <= alu_out; go to IDLE.
- Timing and latency:
  - Accept at cycle T → EXEC during T+2 → wb_valid high during T+3 only.
  - Throughput: one instruction per 3 cycles.
  - wb_valid is 0 in every cycle other than the one following EXEC.
  - wb_rd/wb_data hold their last values until the next writeback.
- ALU driving rule: alu_cmd = 5'b00000 (ZERO) and alu_a = alu_b = 0 in IDLE and READ. Stateful ALU commands (flag load) are therefore presented during EXEC only, exactly once per instruction.
- alu_opm holds the value of the last issued instruction; reset value 0.
- Simultaneous events: in the IDLE cycle where wb_valid=1, in_ready is also 1 and a new accept is legal.
- A writeback's regfile update is visible to the READ of the very next instruction.
- Input fields are sampled only on the accept edge; changes while in_ready=0 are ignored.
- Reset, checked every edge and overriding everything:
  - state=IDLE.
  - All registers, including the regfile, = 0.
  - alu_cmd=0, alu_opm=0, alu_a=0, alu_b=0, wb_valid=0, wb_rd=0, wb_data=0.
  - An in-flight instruction is dropped; no writeback occurs, even when reset is asserted during EXEC.
- Immediate width: in_imm is full 64-bit; no sign extension is performed.

Optional Feature:
- Macro: ALU_DISPATCH_RETIRE_CNT_EN.
- Defined: adds output port retire_cnt (out, 32 bits).
  - Increments by 1 on every EXEC→IDLE transition, including rd=0 writebacks.
  - Wraps from 32'hFFFFFFFF to 0.
  - Cleared by reset.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles → in_ready=1, wb_valid=0, alu_cmd=0, alu_a=alu_b=0, all registers read 0.
- Accept cmd=5'b00100 (INV), imm_sel=2'b01, imm=0, rd=1 at T → alu_cmd=00100 and alu_a=0 during T+2 only; wb_valid=1 at T+3 with wb_rd=1, wb_data=64'hFFFFFFFFFFFFFFFF.
- Following accept cmd=5'b00001 (SIGN b), rb=1, rd=2 → wb_data equals the ALU's SIGN(-1) result (-1); a later instruction with ra=2 reads -1.
- Hold in_valid high continuously with 3 queued instructions → accepts at T, T+3, T+6 only; in_ready=0 in READ/EXEC; three wb_valid pulses, one per instruction.
- Instruction with rd=0, cmd=INV, imm=0 → wb_valid=1, wb_data=all-ones; a subsequent read of r0 returns 0.
- Assert rst_n=0 during EXEC of a write to r3 → no wb_valid; r3=0 afterwards. With ALU_DISPATCH_RETIRE_CNT_EN defined, retire_cnt=0 after reset and 3 after three further instructions.
